// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the flag register / condition-code unit and branch logic.
// Condition-code encodings and flag bit positions within {n,c,v,z}.
package flag_cond_unit_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    localparam logic [COND_W-1:0] COND_EQ = 4'd0;
    localparam logic [COND_W-1:0] COND_NE = 4'd1;
    localparam logic [COND_W-1:0] COND_CS = 4'd2;
    localparam logic [COND_W-1:0] COND_CC = 4'd3;
    localparam logic [COND_W-1:0] COND_MI = 4'd4;
    localparam logic [COND_W-1:0] COND_PL = 4'd5;
    localparam logic [COND_W-1:0] COND_VS = 4'd6;
    localparam logic [COND_W-1:0] COND_VC = 4'd7;
    localparam logic [COND_W-1:0] COND_HI = 4'd8;
    localparam logic [COND_W-1:0] COND_LS = 4'd9;
    localparam logic [COND_W-1:0] COND_GE = 4'd10;
    localparam logic [COND_W-1:0] COND_LT = 4'd11;
    localparam logic [COND_W-1:0] COND_GT = 4'd12;
    localparam logic [COND_W-1:0] COND_LE = 4'd13;
    localparam logic [COND_W-1:0] COND_AL = 4'd14;
    localparam logic [COND_W-1:0] COND_NV = 4'd15;

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational condition-code evaluator over the N,C,V,Z flags.
// Shared with the branch/select control.
module cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic              n,
    input  logic              c,
    input  logic              v,
    input  logic              z,
    output logic              true_c
);

    always_comb begin
        true_c = 1'b0;
        case (cond)
            COND_EQ: true_c = z;
            COND_NE: true_c = !z;
            COND_CS: true_c = c;
            COND_CC: true_c = !c;
            COND_MI: true_c = n;
            COND_PL: true_c = !n;
            COND_VS: true_c = v;
            COND_VC: true_c = !v;
            COND_HI: true_c = c & !z;
            COND_LS: true_c = !c | z;
            COND_GE: true_c = (n == v);
            COND_LT: true_c = (n != v);
            COND_GT: true_c = !z & (n == v);
            COND_LE: true_c = z | (n != v);
            COND_AL: true_c = 1'b1;
            COND_NV: true_c = 1'b0;
            default: true_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register plus condition-query handshake and saturating taken counter.
// Optional FLAG_COND_STICKY_V_EN: sticky overflow bit with v_clr input.
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FLAG_COND_STICKY_V_EN
    input  logic              v_clr,
`endif
    input  logic              flag_we,
    input  logic              n_in,
    input  logic              c_in,
    input  logic              v_in,
    input  logic              z_in,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [COND_W-1:0] q_cond,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_true,
    output logic [FLAG_W-1:0] flags_q,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [FLAG_W-1:0] eff_flags;
    logic              accept;
    logic              eval_true;

    // Queries accepted alongside a flag write see the incoming flags.
    always_comb begin
        eff_flags = flags_q;
        if (flag_we) begin
            eff_flags[FLAG_N] = n_in;
            eff_flags[FLAG_C] = c_in;
            eff_flags[FLAG_Z] = z_in;
`ifdef FLAG_COND_STICKY_V_EN
            eff_flags[FLAG_V] = v_clr ? v_in : (flags_q[FLAG_V] | v_in);
`else
            eff_flags[FLAG_V] = v_in;
`endif
        end
    end

    cond_eval u_cond_eval (
        .cond   (q_cond),
        .n      (eff_flags[FLAG_N]),
        .c      (eff_flags[FLAG_C]),
        .v      (eff_flags[FLAG_V]),
        .z      (eff_flags[FLAG_Z]),
        .true_c (eval_true)
    );

    assign q_ready = !r_valid | r_ready;
    assign accept  = q_valid & q_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            if (flag_we) begin
                flags_q[FLAG_N] <= n_in;
                flags_q[FLAG_C] <= c_in;
                flags_q[FLAG_Z] <= z_in;
            end
`ifdef FLAG_COND_STICKY_V_EN
            // Clear wins over a same-edge set.
            if (v_clr) begin
                flags_q[FLAG_V] <= 1'b0;
            end else if (flag_we) begin
                flags_q[FLAG_V] <= flags_q[FLAG_V] | v_in;
            end
`else
            if (flag_we) begin
                flags_q[FLAG_V] <= v_in;
            end
`endif
        end
    end

    // One-entry result register; drain and accept in the same cycle keep full rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_true  <= 1'b0;
        end else if (accept) begin
            r_valid <= 1'b1;
            r_true  <= eval_true;
        end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt <= '0;
        end else if (accept && eval_true && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Randomized plus directed bench for flag_cond_unit against a behavioural model.
// Define FLAG_COND_STICKY_V_EN to exercise the sticky overflow variant.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_we, n_in, c_in, v_in, z_in;
    logic       q_valid, r_ready;
    logic [3:0] q_cond;
`ifdef FLAG_COND_STICKY_V_EN
    logic       v_clr;
`endif

    logic       q_ready, r_valid, r_true;
    logic       q_ready2, r_valid2, r_true2;
    logic [3:0] flags_q, flags_q2;
    logic [7:0] taken_cnt;
    logic [1:0] taken_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_cond_unit #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
`ifdef FLAG_COND_STICKY_V_EN
        .v_clr(v_clr),
`endif
        .flag_we(flag_we), .n_in(n_in), .c_in(c_in), .v_in(v_in), .z_in(z_in),
        .q_valid(q_valid), .q_ready(q_ready), .q_cond(q_cond),
        .r_valid(r_valid), .r_ready(r_ready), .r_true(r_true),
        .flags_q(flags_q), .taken_cnt(taken_cnt)
    );

    flag_cond_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
`ifdef FLAG_COND_STICKY_V_EN
        .v_clr(v_clr),
`endif
        .flag_we(flag_we), .n_in(n_in), .c_in(c_in), .v_in(v_in), .z_in(z_in),
        .q_valid(q_valid), .q_ready(q_ready2), .q_cond(q_cond),
        .r_valid(r_valid2), .r_ready(r_ready), .r_true(r_true2),
        .flags_q(flags_q2), .taken_cnt(taken_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in pairs; the odd code of each pair is the negation of the even one.
    function automatic logic cond_holds(input logic [3:0] cond, input logic n, c, v, z);
        logic base;
        case (cond >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = !(n ^ v);
            6: base = !z && !(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    // Behavioural model: flags as separate bits, counter as an unbounded integer.
    logic m_n, m_c, m_v, m_z, m_rv, m_rt;
    int   m_cnt;

    always @(posedge clk or posedge rst) begin
        logic fn, fc, fv, fz, res;
        if (rst) begin
            {m_n, m_c, m_v, m_z} = 4'b0000;
            m_rv = 1'b0; m_rt = 1'b0; m_cnt = 0;
        end else begin
            fn = m_n; fc = m_c; fv = m_v; fz = m_z;
            if (flag_we) begin
                fn = n_in; fc = c_in; fz = z_in;
`ifdef FLAG_COND_STICKY_V_EN
                fv = v_clr ? v_in : (m_v | v_in);
`else
                fv = v_in;
`endif
            end
            res = cond_holds(q_cond, fn, fc, fv, fz);
            if (q_valid && (!m_rv || r_ready)) begin
                m_rv = 1'b1; m_rt = res;
                if (res) m_cnt++;
            end else if (m_rv && r_ready) begin
                m_rv = 1'b0;
            end
            if (flag_we) begin m_n = n_in; m_c = c_in; m_z = z_in; end
`ifdef FLAG_COND_STICKY_V_EN
            if (v_clr) m_v = 1'b0;
            else if (flag_we) m_v = m_v | v_in;
`else
            if (flag_we) m_v = v_in;
`endif
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("q_ready",   32'(q_ready),   32'(!m_rv || r_ready));
        chk("r_valid",   32'(r_valid),   32'(m_rv));
        chk("r_true",    32'(r_true),    32'(m_rt));
        chk("flags_q",   32'(flags_q),   32'({m_n, m_c, m_v, m_z}));
        chk("taken_cnt", 32'(taken_cnt), 32'((m_cnt > 255) ? 255 : m_cnt));
        chk("taken_cnt2",32'(taken_cnt2),32'((m_cnt > 3) ? 3 : m_cnt));
        chk("r_valid2",  32'(r_valid2),  32'(m_rv));
        chk("r_true2",   32'(r_true2),   32'(m_rt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flag_we = 0; q_valid = 0;
`ifdef FLAG_COND_STICKY_V_EN
        v_clr = 0;
`endif
    endtask

    task automatic load(input logic [3:0] f);
        flag_we = 1'b1;
        {n_in, c_in, v_in, z_in} = f;
    endtask

    task automatic query(input logic [3:0] cond);
        q_valid = 1'b1;
        q_cond = cond;
    endtask

    initial begin
        logic [15:0] exp_seq;
        logic [15:0] got_seq;
        exp_seq = 16'b0110_0110_1010_0101;
        got_seq = '0;
        rst = 1'b1; r_ready = 1'b1; q_cond = 4'd0;
        {n_in, c_in, v_in, z_in} = 4'b0000;
        idle();
        tick(); tick();
        chk("rst_flags", 32'(flags_q), 32'h0);
        chk("rst_rvalid", 32'(r_valid), 32'h0);
        chk("rst_cnt", 32'(taken_cnt), 32'h0);
        chk("rst_qready", 32'(q_ready), 32'h1);
        rst = 1'b0;
        query(4'd0);
        tick();
        chk("eq_after_rst_valid", 32'(r_valid), 32'h1);
        chk("eq_after_rst_true", 32'(r_true), 32'h0);

        // Load {n,c,v,z}=0101 then sweep every condition code.
        idle(); load(4'b0101);
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            query(4'(i));
            tick();
            got_seq[i] = r_true;
        end
        idle();
        chk("sweep_seq", 32'(got_seq), 32'(exp_seq));
        chk("sweep_cnt", 32'(taken_cnt), 32'd8);
        chk("sweep_model_cnt", 32'(m_cnt), 32'd8);
        chk("sweep_cnt2", 32'(taken_cnt2), 32'd3);

        // Same-cycle flag write forwards into the query.
        load(4'b0000); tick();
        load(4'b1000); query(4'd4); tick();
        idle();
        chk("fwd_mi", 32'(r_true), 32'h1);

        // Backpressure with a flag write during the stall.
        r_ready = 1'b0; query(4'd14); tick();
        query(4'd1);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) load(4'b0001); else flag_we = 1'b0;
            #1;
            chk("stall_qready", 32'(q_ready), 32'h0);
            chk("stall_rvalid", 32'(r_valid), 32'h1);
            chk("stall_rtrue", 32'(r_true), 32'h1);
            tick();
        end
        flag_we = 1'b0;
        r_ready = 1'b1;
        #1;
        chk("drain_qready", 32'(q_ready), 32'h1);
        tick();
        chk("b2b_rvalid", 32'(r_valid), 32'h1);
        chk("b2b_rtrue_ne", 32'(r_true), 32'h0);
        idle(); tick();
        chk("drained", 32'(r_valid), 32'h0);

        // Reset mid-handshake drops the result and clears counters.
        r_ready = 1'b0; query(4'd14); tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0; r_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rvalid", 32'(r_valid), 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            query(4'd14); tick();
        end
        idle(); tick();
        chk("sat_cnt2", 32'(taken_cnt2), 32'd3);
        chk("sat_cnt8", 32'(taken_cnt), 32'd6);
        query(4'd14); tick(); idle(); tick();
        chk("sat_cnt2_hold", 32'(taken_cnt2), 32'd3);

`ifdef FLAG_COND_STICKY_V_EN
        load(4'b0010); tick();
        load(4'b0000); tick();
        idle(); query(4'd6); tick(); idle();
        chk("sticky_vs", 32'(r_true), 32'h1);
        v_clr = 1'b1; tick(); v_clr = 1'b0;
        query(4'd6); tick(); idle();
        chk("vclr_vs", 32'(r_true), 32'h0);
        v_clr = 1'b1; load(4'b0010); tick(); idle();
        chk("vclr_prio", 32'(flags_q[1]), 32'h0);
        query(4'd6); tick(); idle();
        chk("vclr_prio_vs", 32'(r_true), 32'h0);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            flag_we = $urandom_range(0, 2) == 0;
            {n_in, c_in, v_in, z_in} = 4'($urandom);
            q_valid = $urandom_range(0, 3) != 0;
            q_cond  = 4'($urandom);
            r_ready = $urandom_range(0, 2) != 0;
`ifdef FLAG_COND_STICKY_V_EN
            v_clr   = $urandom_range(0, 9) == 0;
`endif
            tick();
        end
        rst = 1'b0; idle(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer side of the adder flag interface: latches {n,c,v,z} produced by flag_circuit into an architectural flag register.
- Answers condition-code queries against those flags through a valid/ready handshake.
- Sits between the ALU datapath (full_adder + flag_circuit) and the branch/select control that decides taken/not-taken.
- Keeps a saturating count of true conditions for debug.

Parameters:
- CNT_W, 8, width of the saturating taken counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- flag_we  input  1  load flags this cycle.
- n_in  input  1  negative flag from flag_circuit.
- c_in  input  1  carry flag.
- v_in  input  1  overflow flag.
- z_in  input  1  zero flag.
- q_valid  input  1  condition query present.
- q_ready  output  1  unit accepts the query.
- q_cond  input  4  condition code.
- r_valid  output  1  result available.
- r_ready  input  1  consumer takes the result.
- r_true  output  1  condition evaluated true.
- flags_q  output  4  registered flags {n,c,v,z}, MSB to LSB.
- taken_cnt  output  CNT_W  saturating count of accepted queries that evaluated true.

Behaviour:
- Reset (async, immediate):
  - flags_q=4'b0000; r_valid=0; r_true=0; taken_cnt=0.
  - An in-flight result is discarded.
  - q_ready is not reset-gated (combinational); it evaluates 1 during reset.
- Flag register: on a clk edge with flag_we=1, flags_q <= {n_in,c_in,v_in,z_in}. Otherwise it holds.
- Condition codes, evaluated on effective flags N,C,V,Z:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- Forwarding: when flag_we=1 in the same cycle a query is accepted, the query evaluates against {n_in,c_in,v_in,z_in}, not the stale flags_q.
- Handshake, 1-entry output register:
  - q_ready = !r_valid | r_ready.
  - Accept = q_valid & q_ready.
  - On accept: r_valid<=1 and r_true<=eval, giving 1-cycle latency.
  - On r_valid & r_ready without accept: r_valid<=0.
  - Simultaneous drain and accept gives back-to-back results at 1 per cycle, with no bubble.
- Stall: while r_valid & !r_ready, r_true and r_valid hold stable and q_ready=0. Flag writes still proceed.
- taken_cnt:
  - Increments on accept when eval=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset mid-handshake: result dropped and counter cleared; the consumer must not see r_valid after rst deasserts until a new accept.

Optional Feature:
- Macro FLAG_COND_STICKY_V_EN.
- Defined:
  - Adds input v_clr (1 bit).
  - The V bit of flags_q becomes sticky: flag_we ORs v_in into the stored V instead of replacing it.
  - v_clr=1 clears V at the edge; v_clr has priority over a simultaneous set.
  - The forwarded V for same-cycle queries is stored V | v_in, or v_in alone when v_clr=1.
- Undefined: v_clr is absent, and V loads like the other flags.

Decomposition:
- Shared package holds:
  - Condition-code localparams COND_EQ..COND_NV (4-bit).
  - Flag bit indices FLAG_N=3, FLAG_C=2, FLAG_V=1, FLAG_Z=0.
- One natural combinational sub-module, cond_eval: (cond[3:0], n,c,v,z) -> true. Reused by later branch logic.
- Flag register, handshake and counter stay in flag_cond_unit.

Test Plan:
- Reset check: assert rst -> flags_q=0000, r_valid=0, taken_cnt=0. Deassert, query EQ with r_ready=1 -> next cycle r_valid=1, r_true=0.
- Flag load and codes: load a=~0, b=1 flags {0,1,0,1}, then sweep q_cond 0..15 with r_ready=1. Expect r_true sequence 1,0,1,0,0,1,0,1,0,1,1,0,0,1,1,0; taken_cnt=8.
- Forwarding: flags_q=0000; same cycle flag_we=1 with {1,0,0,0} and query MI -> r_true=1.
- Backpressure: r_ready=0 after accept of AL. Expect q_ready=0, r_valid/r_true hold for 3 cycles. Raise r_ready with q_valid=1 NE -> next result is accepted in the same cycle as the drain.
- Saturation: CNT_W=2, issue 6 AL queries -> taken_cnt=3 and stays 3.
- Sticky V (FLAG_COND_STICKY_V_EN):
  - Load V=1, then load V=0 -> VS true.
  - Pulse v_clr -> VS false.
  - v_clr and flag_we with v_in=1 in the same cycle -> V=0.
